// File: rtl/banked_memory.sv
// WIDTH x DEPTH data/scratch memory: two combinational read ports, one synchronous
// write port, a probe tap, a handshaked bulk-clear engine and a write-error flag.
module banked_memory #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int INIT_IDX  = 1,
  parameter int INIT_VAL  = 1,
  parameter int PROBE_IDX = 15,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic [WIDTH-1:0] probe,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done,
  output logic             wr_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok;
  logic              clr_wr;

  function automatic logic [WIDTH-1:0] img(input int idx);
    return (idx == INIT_IDX) ? WIDTH'(INIT_VAL) : '0;
  endfunction

  // Addresses at or beyond DEPTH exist when DEPTH is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Clear handshake: clr_req is sampled only in IDLE and never queued; busy is high
  // for exactly the DEPTH clearing cycles, then clr_done pulses for one cycle.
  assign wr_ok  = we && (state_q == IDLE) && in_range(waddr);
  assign clr_wr = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (32'(cnt_q) == DEPTH - 1) state_d = DONE;
        else                         cnt_d   = cnt_q + AW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy     <= (state_d == CLEAR);
      clr_done <= (state_d == DONE);
      wr_err   <= we && !wr_ok;
    end
  end

  // A write accepted together with clr_req lands first; the clear then restores it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= img(i);
    end else if (clr_wr) begin
      mem[cnt_q] <= img(32'(cnt_q));
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a   = in_range(raddr_a) ? mem[raddr_a] : '0;
  assign rdata_b   = in_range(raddr_b) ? mem[raddr_b] : '0;
  assign probe     = mem[PROBE_IDX];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_banked_memory.sv
// Directed bench for banked_memory: default 32-word instance plus a 24-word instance
// for out-of-range addressing; table-driven read/write vectors and clear sequences.
module tb_banked_memory;

  logic       clk = 1'b0;
  logic       reset;
  logic       we, clr_req;
  logic [4:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata, rdata_a, rdata_b, probe;
  logic       busy, clr_done, wr_err;
  logic [1:0] dbg_state;

  logic       we_s, clr_req_s;
  logic [4:0] waddr_s, raddr_a_s, raddr_b_s;
  logic [7:0] wdata_s, rdata_a_s, rdata_b_s, probe_s;
  logic       busy_s, clr_done_s, wr_err_s;
  logic [1:0] dbg_state_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  banked_memory dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .probe(probe), .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .wr_err(wr_err), .dbg_state(dbg_state)
  );

  banked_memory #(.DEPTH(24)) dut_s (
    .clk(clk), .reset(reset), .we(we_s), .waddr(waddr_s), .wdata(wdata_s),
    .raddr_a(raddr_a_s), .rdata_a(rdata_a_s), .raddr_b(raddr_b_s), .rdata_b(rdata_b_s),
    .probe(probe_s), .clr_req(clr_req_s), .busy(busy_s), .clr_done(clr_done_s),
    .wr_err(wr_err_s), .dbg_state(dbg_state_s)
  );

  typedef struct {
    logic       we;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ep;
    logic       eerr;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] img(input int i);
    return (i == 1) ? 8'h01 : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_image(input string tag);
    logic [7:0] exp_q[$];
    for (int i = 0; i < 32; i++) exp_q.push_back(img(i));
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i);
      raddr_b = 5'(31 - i);
      #1;
      check({tag, "_a"}, 32'(rdata_a), 32'(exp_q[i]));
      check({tag, "_b"}, 32'(rdata_b), 32'(exp_q[31 - i]));
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic start_clear();
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    we      = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns how many samples showed busy high.
  task automatic count_busy(input bit inject, output int busy_cnt);
    busy_cnt = 0;
    while (busy && busy_cnt < 100) begin
      busy_cnt++;
      if (inject && busy_cnt == 2) begin
        we = 1'b1; waddr = 5'd0; wdata = 8'h42; clr_req = 1'b1;
      end
      @(posedge clk); #1;
      if (inject && busy_cnt == 2) begin
        check("busy_write_wr_err", 32'(wr_err), 32'd1);
        we = 1'b0; clr_req = 1'b0;
      end
    end
  endtask

  initial begin
    int bc;
    int seen;

    vecs[0] = '{1'b1, 5'd3,  8'hA5, 5'd3,  5'd1,  8'hA5, 8'h01, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 5'd15, 8'h5A, 5'd3,  5'd15, 8'hA5, 8'h5A, 8'h5A, 1'b0};
    vecs[2] = '{1'b0, 5'd0,  8'h00, 5'd0,  5'd2,  8'h00, 8'h00, 8'h5A, 1'b0};
    vecs[3] = '{1'b1, 5'd31, 8'hC3, 5'd31, 5'd30, 8'hC3, 8'h00, 8'h5A, 1'b0};
    vecs[4] = '{1'b1, 5'd1,  8'h77, 5'd1,  5'd3,  8'h77, 8'hA5, 8'h5A, 1'b0};
    vecs[5] = '{1'b0, 5'd0,  8'h00, 5'd15, 5'd15, 8'h5A, 8'h5A, 8'h5A, 1'b0};

    reset = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = 5'd1; clr_req = 1'b0;
    we_s = 1'b0; waddr_s = '0; wdata_s = '0; raddr_a_s = '0; raddr_b_s = 5'd1; clr_req_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    check("rst_rdata_a0", 32'(rdata_a), 32'h00);
    check("rst_rdata_b1", 32'(rdata_b), 32'h01);
    check("rst_probe", 32'(probe), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_s_rdata_b1", 32'(rdata_b_s), 32'h01);
    check("rst_s_busy", 32'(busy_s), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // dual read / write vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
      @(posedge clk); #1;
      check($sformatf("vec%0d_rdata_a", i), 32'(rdata_a), 32'(vecs[i].ea));
      check($sformatf("vec%0d_rdata_b", i), 32'(rdata_b), 32'(vecs[i].eb));
      check($sformatf("vec%0d_probe", i), 32'(probe), 32'(vecs[i].ep));
      check($sformatf("vec%0d_wr_err", i), 32'(wr_err), 32'(vecs[i].eerr));
      we = 1'b0;
    end

    // same-cycle read of the write address
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 8'hFF; raddr_a = 5'd3;
    #1;
    check("rdw_old", 32'(rdata_a), 32'hA5);
    @(posedge clk); #1;
    we = 1'b0;
    check("rdw_new", 32'(rdata_a), 32'hFF);

    // out-of-range write/read on the 24-word instance
    @(negedge clk);
    we_s = 1'b1; waddr_s = 5'd30; wdata_s = 8'hAA; raddr_a_s = 5'd30;
    @(posedge clk); #1;
    we_s = 1'b0;
    check("oor_wr_err", 32'(wr_err_s), 32'd1);
    check("oor_rdata", 32'(rdata_a_s), 32'h00);
    @(posedge clk); #1;
    check("oor_wr_err_drop", 32'(wr_err_s), 32'd0);
    for (int i = 0; i < 24; i++) begin
      raddr_b_s = 5'(i);
      #1;
      check($sformatf("oor_word%0d", i), 32'(rdata_b_s), 32'(img(i)));
    end
    check("oor_probe", 32'(probe_s), 32'h00);
    @(negedge clk);
    we_s = 1'b1; waddr_s = 5'd23; wdata_s = 8'h3C; raddr_a_s = 5'd23;
    @(posedge clk); #1;
    we_s = 1'b0;
    check("s_last_word", 32'(rdata_a_s), 32'h3C);
    check("s_last_wr_err", 32'(wr_err_s), 32'd0);
    check("s_state", 32'(dbg_state_s), 32'd0);

    // full clear after filling with EE
    for (int i = 0; i < 32; i++) wr(5'(i), 8'hEE);
    raddr_a = 5'd0; raddr_b = 5'd1;
    #1;
    check("fill_word0", 32'(rdata_a), 32'hEE);
    check("fill_word1", 32'(rdata_b), 32'hEE);
    check("fill_probe", 32'(probe), 32'hEE);
    start_clear();
    count_busy(1'b0, bc);
    check("clr_busy_cycles", 32'(bc), 32'd32);
    check("clr_done_pulse", 32'(clr_done), 32'd1);
    @(posedge clk); #1;
    check("clr_done_end", 32'(clr_done), 32'd0);
    check("clr_busy_end", 32'(busy), 32'd0);
    check_image("clr_img");

    // write and clr_req during busy are dropped
    wr(5'd5, 8'h99);
    start_clear();
    count_busy(1'b1, bc);
    check("coll_busy_cycles", 32'(bc), 32'd32);
    check("coll_done_pulse", 32'(clr_done), 32'd1);
    @(posedge clk); #1;
    check("coll_no_restart", 32'(busy), 32'd0);
    check("coll_done_end", 32'(clr_done), 32'd0);
    check_image("coll_img");

    // write together with clr_req in IDLE
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 8'hBB; clr_req = 1'b1; raddr_b = 5'd7;
    @(posedge clk); #1;
    we = 1'b0; clr_req = 1'b0;
    check("wr_clr_commit", 32'(rdata_b), 32'hBB);
    count_busy(1'b0, bc);
    check("wr_clr_busy_cycles", 32'(bc), 32'd32);
    @(posedge clk); #1;
    check_image("wr_clr_img");

    // reset in the middle of a clear
    for (int i = 0; i < 32; i++) wr(5'(i), 8'hEE);
    start_clear();
    repeat (10) @(posedge clk);
    #1;
    raddr_a = 5'd0; raddr_b = 5'd20;
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_word0_cleared", 32'(rdata_a), 32'h00);
    check("mid_word20_old", 32'(rdata_b), 32'hEE);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_probe", 32'(probe), 32'h00);
    check_image("mid_rst_img");
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (clr_done || busy) seen++;
    end
    check("mid_rst_no_done", 32'(seen), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
